// File: rtl/alu_ctrl_pipe_if.sv
// Handshake bundle between instruction decode and alu_ctrl_pipe.
// The producer/consumer side uses master; the decoder itself uses slave.
interface alu_ctrl_pipe_if #(
  parameter int CTRL_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] alu_op;
  logic              jump_register;
  logic              illegal;

  modport master (
    output in_valid, opcode, funct, out_ready,
    input  in_ready, out_valid, alu_op, jump_register, illegal
  );

  modport slave (
    input  in_valid, opcode, funct, out_ready,
    output in_ready, out_valid, alu_op, jump_register, illegal
  );
endinterface

// File: rtl/alu_ctrl_pipe.sv
// Registered MIPS ALU control decoder with valid/ready output stage.
// Define ALU_CTRL_MULDIV_EN to decode mult/div as multi-cycle ops (BUSY state + counter).

module alu_ctrl_pipe_chk #(
  parameter int CTRL_W        = 5,
  parameter int MULDIV_CYCLES = 4
) (
  input logic              clk,
  input logic              reset,
  input logic              in_ready,
  input logic              out_valid,
  input logic              out_ready,
  input logic [CTRL_W-1:0] alu_op,
  input logic              jump_register,
  input logic              illegal
);
  a_cfg: assert property (@(posedge clk) (CTRL_W >= 5) && (MULDIV_CYCLES >= 2));

  a_reset_blocks: assert property (@(posedge clk) reset |-> !in_ready);

  a_hold: assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready) |=> (out_valid && $stable(alu_op) &&
                                   $stable(jump_register) && $stable(illegal)));

  a_illegal_code: assert property (@(posedge clk) disable iff (reset)
    illegal |-> ((alu_op == {CTRL_W{1'b1}}) && !jump_register));
endmodule

module alu_ctrl_pipe #(
  parameter int CTRL_W        = 5,
  parameter int MULDIV_CYCLES = 4
) (
  input logic            clk,
  input logic            reset,
  alu_ctrl_pipe_if.slave bus
);

`ifdef ALU_CTRL_MULDIV_EN
  localparam int CNT_W = $clog2(MULDIV_CYCLES);
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_FULL = 2'd1, ST_BUSY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_FULL = 2'd1} state_t;
`endif

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CTRL_W-1:0] alu_op_r;
  logic              jr_r;
  logic              ill_r;
  logic [4:0]        dec_code_s;
  logic [CTRL_W-1:0] dec_op_s;
  logic              dec_jr_s;
  logic              dec_ill_s;
  logic              in_ready_s;
  logic              accept_s;
`ifdef ALU_CTRL_MULDIV_EN
  logic              dec_md_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
`endif

  // Instruction decode; codes are 5-bit legacy values zero-extended to CTRL_W.
  always_comb begin
    dec_code_s = 5'b00000;
    dec_jr_s   = 1'b0;
    dec_ill_s  = 1'b0;
`ifdef ALU_CTRL_MULDIV_EN
    dec_md_s   = 1'b0;
`endif
    case (bus.opcode)
      6'b000000: begin
        case (bus.funct)
          6'b100000: dec_code_s = 5'b00010;
          6'b100010: dec_code_s = 5'b00101;
          6'b100100: dec_code_s = 5'b00000;
          6'b100101: dec_code_s = 5'b01101;
          6'b100111: dec_code_s = 5'b01100;
          6'b101010: dec_code_s = 5'b00111;
          6'b000000: dec_code_s = 5'b00100;
          6'b000010: dec_code_s = 5'b00110;
          6'b001000: begin
            dec_code_s = 5'b01111;
            dec_jr_s   = 1'b1;
          end
`ifdef ALU_CTRL_MULDIV_EN
          6'b011000: begin
            dec_code_s = 5'b10000;
            dec_md_s   = 1'b1;
          end
          6'b011010: begin
            dec_code_s = 5'b10001;
            dec_md_s   = 1'b1;
          end
`endif
          default:   dec_ill_s = 1'b1;
        endcase
      end
      6'b100011: dec_code_s = 5'b01000;
      6'b101011: dec_code_s = 5'b01001;
      6'b001000: dec_code_s = 5'b00011;
      6'b001100: dec_code_s = 5'b00001;
      6'b001101: dec_code_s = 5'b01101;
      6'b000100: dec_code_s = 5'b01010;
      6'b000101: dec_code_s = 5'b01110;
      6'b000011: dec_code_s = 5'b01011;
      6'b000010: dec_code_s = 5'b01011;
      default:   dec_ill_s  = 1'b1;
    endcase
    // Illegal is all ones at full width, not a zero-extended code.
    if (dec_ill_s) begin
      dec_op_s = {CTRL_W{1'b1}};
    end else begin
      dec_op_s = CTRL_W'(dec_code_s);
    end
  end

  // Ready/accept: drain and refill in the same cycle keeps full throughput.
  always_comb begin
    in_ready_s = 1'b0;
    if (reset) begin
      in_ready_s = 1'b0;
    end else begin
      in_ready_s = (state_r == ST_EMPTY) || ((state_r == ST_FULL) && bus.out_ready);
    end
    accept_s = bus.in_valid && in_ready_s;
  end

  // Next-state logic for the EMPTY/FULL(/BUSY) output stage.
  always_comb begin
    state_nxt_s = state_r;
`ifdef ALU_CTRL_MULDIV_EN
    cnt_nxt_s   = cnt_r;
`endif
    case (state_r)
      ST_EMPTY, ST_FULL: begin
        if (accept_s) begin
`ifdef ALU_CTRL_MULDIV_EN
          if (dec_md_s) begin
            state_nxt_s = ST_BUSY;
            cnt_nxt_s   = CNT_W'(MULDIV_CYCLES - 1);
          end else begin
            state_nxt_s = ST_FULL;
          end
`else
          state_nxt_s = ST_FULL;
`endif
        end else if ((state_r == ST_FULL) && bus.out_ready) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = state_r;
        end
      end
`ifdef ALU_CTRL_MULDIV_EN
      ST_BUSY: begin
        // Counter only runs here and always starts >= 1, so it never wraps.
        cnt_nxt_s = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          state_nxt_s = ST_FULL;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
`endif
      default: state_nxt_s = ST_EMPTY;
    endcase
  end

  // State and output registers; outputs only change on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_EMPTY;
      alu_op_r <= {CTRL_W{1'b0}};
      jr_r     <= 1'b0;
      ill_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        alu_op_r <= dec_op_s;
        jr_r     <= dec_jr_s;
        ill_r    <= dec_ill_s;
      end
    end
  end

`ifdef ALU_CTRL_MULDIV_EN
  // mult/div occupancy counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end
`endif

  assign bus.in_ready      = in_ready_s;
  assign bus.out_valid     = (state_r == ST_FULL);
  assign bus.alu_op        = alu_op_r;
  assign bus.jump_register = jr_r;
  assign bus.illegal       = ill_r;

  alu_ctrl_pipe_chk #(
    .CTRL_W        (CTRL_W),
    .MULDIV_CYCLES (MULDIV_CYCLES)
  ) u_chk (
    .clk           (clk),
    .reset         (reset),
    .in_ready      (bus.in_ready),
    .out_valid     (bus.out_valid),
    .out_ready     (bus.out_ready),
    .alu_op        (bus.alu_op),
    .jump_register (bus.jump_register),
    .illegal       (bus.illegal)
  );

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Directed self-checking bench for alu_ctrl_pipe (CTRL_W=5, MULDIV_CYCLES=4).
module tb_alu_ctrl_pipe;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  alu_ctrl_pipe_if #(.CTRL_W(5)) bus ();

  alu_ctrl_pipe #(
    .CTRL_W        (5),
    .MULDIV_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {opcode, funct, alu_op, jump_register, illegal}
  localparam int NVEC = 20;
  localparam logic [18:0] VEC [NVEC] = '{
    {6'b000000, 6'b100000, 5'b00010, 1'b0, 1'b0},  // add
    {6'b100011, 6'b010101, 5'b01000, 1'b0, 1'b0},  // lw
    {6'b000100, 6'b100000, 5'b01010, 1'b0, 1'b0},  // beq
    {6'b000000, 6'b001000, 5'b01111, 1'b1, 1'b0},  // jr
    {6'b000000, 6'b100010, 5'b00101, 1'b0, 1'b0},  // sub
    {6'b000000, 6'b100100, 5'b00000, 1'b0, 1'b0},  // and
    {6'b000000, 6'b100101, 5'b01101, 1'b0, 1'b0},  // or
    {6'b000000, 6'b100111, 5'b01100, 1'b0, 1'b0},  // nor
    {6'b000000, 6'b101010, 5'b00111, 1'b0, 1'b0},  // slt
    {6'b000000, 6'b000000, 5'b00100, 1'b0, 1'b0},  // sll
    {6'b000000, 6'b000010, 5'b00110, 1'b0, 1'b0},  // srl
    {6'b101011, 6'b001000, 5'b01001, 1'b0, 1'b0},  // sw
    {6'b001000, 6'b001000, 5'b00011, 1'b0, 1'b0},  // addi
    {6'b001100, 6'b111111, 5'b00001, 1'b0, 1'b0},  // andi
    {6'b001101, 6'b000000, 5'b01101, 1'b0, 1'b0},  // ori
    {6'b000101, 6'b011000, 5'b01110, 1'b0, 1'b0},  // bne
    {6'b000011, 6'b000000, 5'b01011, 1'b0, 1'b0},  // jal
    {6'b000010, 6'b100000, 5'b01011, 1'b0, 1'b0},  // j
    {6'b111111, 6'b100000, 5'b11111, 1'b0, 1'b1},  // bad opcode
    {6'b000000, 6'b111111, 5'b11111, 1'b0, 1'b1}   // bad funct
  };

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn);
    bus.in_valid = v;
    bus.opcode   = op;
    bus.funct    = fn;
  endtask

  initial begin
    logic [18:0] v;
    checks   = 0;
    failures = 0;
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 6'b000000, 6'b100000);

    // Reset cycle with in_valid high
    tick();
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b0;
    drive(1'b0, 6'b000000, 6'b000000);
    tick();
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_alu_op", 32'(bus.alu_op), 32'd0);
    check_eq("rst_illegal", 32'(bus.illegal), 32'd0);
    check_eq("rst_jr", 32'(bus.jump_register), 32'd0);
    check_eq("rst_in_ready_after", 32'(bus.in_ready), 32'd1);

    // Back-to-back stream, one op per cycle
    for (int i = 0; i < NVEC; i++) begin
      v = VEC[i];
      drive(1'b1, v[18:13], v[12:7]);
      #1;
      check_eq($sformatf("stream_in_ready[%0d]", i), 32'(bus.in_ready), 32'd1);
      tick();
      check_eq($sformatf("stream_out_valid[%0d]", i), 32'(bus.out_valid), 32'd1);
      check_eq($sformatf("stream_alu_op[%0d]", i), 32'(bus.alu_op), 32'(v[6:2]));
      check_eq($sformatf("stream_jr[%0d]", i), 32'(bus.jump_register), 32'(v[1]));
      check_eq($sformatf("stream_illegal[%0d]", i), 32'(bus.illegal), 32'(v[0]));
    end
    drive(1'b0, 6'b000000, 6'b000000);
    tick();
    check_eq("drain_out_valid", 32'(bus.out_valid), 32'd0);

    // Backpressure: sub held while out_ready low, then ori taken on release
    bus.out_ready = 1'b0;
    drive(1'b1, 6'b000000, 6'b100010);
    #1;
    check_eq("bp_accept_ready", 32'(bus.in_ready), 32'd1);
    tick();
    drive(1'b1, 6'b001101, 6'b000000);
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq($sformatf("bp_out_valid[%0d]", k), 32'(bus.out_valid), 32'd1);
      check_eq($sformatf("bp_alu_op[%0d]", k), 32'(bus.alu_op), 32'h05);
      check_eq($sformatf("bp_in_ready[%0d]", k), 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 32'(bus.in_ready), 32'd1);
    check_eq("bp_release_alu_op", 32'(bus.alu_op), 32'h05);
    tick();
    check_eq("bp_ori_valid", 32'(bus.out_valid), 32'd1);
    check_eq("bp_ori_alu_op", 32'(bus.alu_op), 32'h0d);
    drive(1'b0, 6'b000000, 6'b000000);
    tick();
    check_eq("bp_drain", 32'(bus.out_valid), 32'd0);

`ifdef ALU_CTRL_MULDIV_EN
    // mult: accept at cycle 0, busy 1..3, result at cycle 4
    drive(1'b1, 6'b000000, 6'b011000);
    #1;
    check_eq("mult_accept_ready", 32'(bus.in_ready), 32'd1);
    tick();
    drive(1'b1, 6'b000000, 6'b100000);
    for (int c = 1; c <= 3; c++) begin
      #1;
      check_eq($sformatf("mult_busy_ready[%0d]", c), 32'(bus.in_ready), 32'd0);
      check_eq($sformatf("mult_busy_valid[%0d]", c), 32'(bus.out_valid), 32'd0);
      tick();
    end
    check_eq("mult_out_valid", 32'(bus.out_valid), 32'd1);
    check_eq("mult_alu_op", 32'(bus.alu_op), 32'h10);
    check_eq("mult_illegal", 32'(bus.illegal), 32'd0);
    check_eq("mult_next_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check_eq("after_mult_add", 32'(bus.alu_op), 32'h02);
    drive(1'b0, 6'b000000, 6'b000000);
    tick();

    // div aborted by reset at cycle 2
    drive(1'b1, 6'b000000, 6'b011010);
    tick();
    drive(1'b0, 6'b000000, 6'b000000);
    tick();
    reset = 1'b1;
    #1;
    check_eq("abort_rst_ready", 32'(bus.in_ready), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check_eq("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("abort_alu_op", 32'(bus.alu_op), 32'd0);
    check_eq("abort_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    tick();
    tick();
    check_eq("abort_no_late_valid", 32'(bus.out_valid), 32'd0);
`else
    // mult/div decode as single-cycle illegal ops
    drive(1'b1, 6'b000000, 6'b011010);
    #1;
    check_eq("div_accept_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check_eq("div_out_valid", 32'(bus.out_valid), 32'd1);
    check_eq("div_alu_op", 32'(bus.alu_op), 32'h1f);
    check_eq("div_illegal", 32'(bus.illegal), 32'd1);
    drive(1'b1, 6'b000000, 6'b011000);
    #1;
    check_eq("mult_accept_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check_eq("mult_out_valid", 32'(bus.out_valid), 32'd1);
    check_eq("mult_alu_op", 32'(bus.alu_op), 32'h1f);
    check_eq("mult_illegal", 32'(bus.illegal), 32'd1);
    drive(1'b0, 6'b000000, 6'b000000);
    tick();
    check_eq("muldiv_drain", 32'(bus.out_valid), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
